adder_share_arbiter: RTL

//  Shares one 32-bit carry-skip adder (CSkipA32, 33-bit SUM) between NREQ requesters.

---
 rtl/adder_share_arbiter_pkg.sv | 28 ++
 rtl/adder_share_arbiter_if.sv | 29 ++
 rtl/CSkipA32.sv | 30 +++
 rtl/adder_share_arbiter_rr_pick.sv | 30 +++
 rtl/adder_share_arbiter.sv | 112 +++++++++++
 5 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// adder_arb_pkg: shared types and constants for the shared-adder arbiter.
//   state_t : arbiter FSM encoding (IDLE/EXEC/RESP)
//   op_t    : registered operand pair fed to the adder
//   SUM_W   : adder result width (carry-out included)
//   CNT_W   : completed-transaction counter width
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OP_W  = 32;
  localparam int SUM_W = 33;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_t;

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: request/response bundle between the requesters and
// the shared-adder arbiter.
//   req_valid/req_ready : per-requester request handshake (ready is one-hot)
//   req_a/req_b         : packed operands, slice i = [i*W +: W]
//   rsp_valid/rsp_ready : per-requester response handshake (valid is one-hot)
//   rsp_sum             : W+1 bit result, bit W is the carry-out
//   master : requester side, slave : arbiter side
interface adder_share_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W:0]        rsp_sum;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum
  );
endinterface

// File: rtl/CSkipA32.sv
// CSkipA32: 32-bit unsigned carry-skip adder, no carry-in.
//   a, b : operands
//   sum  : 33-bit result, sum[32] is the carry-out
// Eight 4-bit ripple blocks; a block whose bits all propagate passes its
// carry-in straight through instead of waiting on its internal ripple.
module CSkipA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] sum
);

  always_comb begin
    logic cy, cin, rc, bp;
    sum = '0;
    cy  = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cin = cy;
      rc  = cin;
      bp  = 1'b1;
      for (int k = 0; k < 4; k++) begin
        sum[4*j+k] = a[4*j+k] ^ b[4*j+k] ^ rc;
        rc         = (a[4*j+k] & b[4*j+k]) | ((a[4*j+k] ^ b[4*j+k]) & rc);
        bp         = bp & (a[4*j+k] ^ b[4*j+k]);
      end
      cy = bp ? cin : rc;
    end
    sum[32] = cy;
  end

endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select.
//   req     : request vector
//   ptr     : highest-priority index (scan starts here, wraps modulo NREQ)
//   gnt_idx : index of the first set request at or after ptr
//   any     : at least one request is set (gnt_idx is 0 otherwise)
module rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   gnt_idx,
  output logic            any
);

  always_comb begin
    int idx;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: shares one CSkipA32 between NREQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
//   busy       : FSM is not in IDLE
//   grant_cnt  : completed transactions, wraps at 16 bits
// One add in flight: IDLE (grant) -> EXEC (add from op regs) -> RESP (hold
// result until the granted requester takes it). The adder sees only the
// operand registers, so there is no combinational req_* -> rsp_* path.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_share_arbiter_if.slave bus,
  output logic              busy,
  output logic [CNT_W-1:0]  grant_cnt
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (W != 32) begin : g_w_check
    $error("adder_share_arbiter: W must be 32 to match CSkipA32");
  end

  state_t           state_q;
  logic [GW-1:0]    rr_ptr_q;
  logic [GW-1:0]    gnt_q;
  op_t              op_q;
  logic [W:0]       rsp_sum_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [GW-1:0]    win;
  logic             any;
  logic [NREQ-1:0]  req_ready_c;
  logic             hs;
  logic [W-1:0]     sel_a, sel_b;
  logic [SUM_W-1:0] add_sum;
  logic [NREQ-1:0]  gnt_oh;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (win),
    .any     (any)
  );

  // Ready is offered only in IDLE and never while reset is held, so no
  // handshake can be seen by a requester during reset.
  always_comb begin
    req_ready_c = '0;
    if (rst_n && state_q == IDLE && any) req_ready_c[win] = 1'b1;
  end

  assign hs    = |(bus.req_valid & req_ready_c);
  assign sel_a = bus.req_a[int'(win)*W +: W];
  assign sel_b = bus.req_b[int'(win)*W +: W];
  assign gnt_oh = NREQ'(1) << gnt_q;

  CSkipA32 u_add (
    .a   (op_q.a),
    .b   (op_q.b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      op_q        <= '0;
      rsp_sum_q   <= '0;
      rsp_valid_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            op_q    <= '{a: sel_a, b: sel_b};
            gnt_q   <= win;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= add_sum;
          rsp_valid_q <= gnt_oh;
          state_q     <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready counts.
          if (bus.rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= GW'(rr_next(int'(gnt_q), NREQ));
            cnt_q       <= cnt_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign busy          = (state_q != IDLE);
  assign grant_cnt     = cnt_q;

endmodule
